// File: rtl/matrix_input_parser_if.sv
// Parser-side bundle: start/base and UART byte stream in, Storage write port and m/n/done/err out.
// master = parser, slave = controlling FSM / Storage side.
interface matrix_input_parser_if #(
   parameter int ADDR_W = 8
);
   logic              w_en_input;
   logic [ADDR_W-1:0] w_in_base_addr;
   logic              i_rx_valid;
   logic [7:0]        i_rx_data;
   logic              w_storage_we;
   logic [ADDR_W-1:0] w_storage_waddr;
   logic [31:0]       w_storage_wdata;
   logic [31:0]       o_in_m;
   logic [31:0]       o_in_n;
   logic              w_in_done;
   logic [1:0]        w_in_err;

   modport master (
      input  w_en_input, w_in_base_addr, i_rx_valid, i_rx_data,
      output w_storage_we, w_storage_waddr, w_storage_wdata,
      output o_in_m, o_in_n, w_in_done, w_in_err
   );

   modport slave (
      output w_en_input, w_in_base_addr, i_rx_valid, i_rx_data,
      input  w_storage_we, w_storage_waddr, w_storage_wdata,
      input  o_in_m, o_in_n, w_in_done, w_in_err
   );
endinterface

// File: rtl/matrix_input_parser.sv
// ASCII "m n e0 e1 ..." parser writing a row-major matrix into Storage; write issued 1 cycle after
// the terminating delimiter. No backpressure: accepts a byte every cycle, drops bytes outside parse states.
module matrix_input_parser #(
   parameter int MAX_DIM = 5,
   parameter int MAX_VAL = 9,
   parameter int ADDR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   matrix_input_parser_if.master bus
);
   localparam int CNT_W = $clog2(MAX_DIM * MAX_DIM + 1);
   localparam int DIM_W = $clog2(MAX_DIM + 1);
   localparam logic [9:0] MAX_DIM_A = 10'(MAX_DIM);
   localparam logic [9:0] MAX_VAL_A = 10'(MAX_VAL);
   localparam logic [9:0] ACC_SAT   = 10'd1000;

   typedef enum logic [2:0] {
      S_IDLE, S_GET_M, S_GET_N, S_GET_ELEM, S_FILL, S_DONE, S_ERR
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [9:0]        acc_q, acc_d;
   logic              pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic [9:0]        m_q, m_d;
   logic [9:0]        n_q, n_d;
   logic [1:0]        err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [9:0]        wdata_q, wdata_d;

   logic              is_digit, is_delim, is_eol, dim_ok;
   logic [13:0]       acc_mul;
   logic [9:0]        acc_next;
   logic [CNT_W-1:0]  prod;
   logic [CNT_W-1:0]  cnt_after;

   assign is_digit = (bus.i_rx_data >= 8'd48) && (bus.i_rx_data <= 8'd57);
   assign is_eol   = (bus.i_rx_data == 8'd13) || (bus.i_rx_data == 8'd10);
   assign is_delim = is_eol || (bus.i_rx_data == 8'd32);
   assign acc_mul  = ({4'd0, acc_q} * 14'd10) + {10'd0, bus.i_rx_data[3:0]};
   assign acc_next = (acc_mul > {4'd0, ACC_SAT}) ? ACC_SAT : acc_mul[9:0];
   assign dim_ok   = (acc_q >= 10'd1) && (acc_q <= MAX_DIM_A);
   assign prod     = CNT_W'(m_q[DIM_W-1:0]) * CNT_W'(acc_q[DIM_W-1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         acc_q   <= '0;
         pend_q  <= 1'b0;
         cnt_q   <= '0;
         total_q <= '0;
         m_q     <= '0;
         n_q     <= '0;
         err_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         acc_q   <= acc_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         total_q <= total_d;
         m_q     <= m_d;
         n_q     <= n_d;
         err_q   <= err_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      acc_d     = acc_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      total_d   = total_q;
      m_d       = m_q;
      n_d       = n_q;
      err_d     = err_q;
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      cnt_after = cnt_q + CNT_W'(pend_q);

      case (state_q)
         S_IDLE: begin
            if (bus.w_en_input) begin
               base_d  = bus.w_in_base_addr;
               acc_d   = '0;
               pend_d  = 1'b0;
               cnt_d   = '0;
               err_d   = 2'd0;
               state_d = S_GET_M;
            end
         end
         S_GET_M, S_GET_N, S_GET_ELEM: begin
            if (bus.i_rx_valid) begin
               if (is_digit) begin
                  acc_d  = acc_next;
                  pend_d = 1'b1;
               end else if (!is_delim) begin
                  err_d   = 2'd3;
                  state_d = S_ERR;
               end else begin
                  acc_d  = '0;
                  pend_d = 1'b0;
                  if (state_q == S_GET_M) begin
                     if (pend_q) begin
                        m_d     = acc_q;
                        err_d   = dim_ok ? 2'd0 : 2'd1;
                        state_d = dim_ok ? S_GET_N : S_ERR;
                     end
                  end else if (state_q == S_GET_N) begin
                     if (pend_q) begin
                        n_d     = acc_q;
                        total_d = prod;
                        err_d   = dim_ok ? 2'd0 : 2'd1;
                        state_d = dim_ok ? S_GET_ELEM : S_ERR;
                     end
                  end else if (pend_q && (acc_q > MAX_VAL_A)) begin
                     err_d   = 2'd2;
                     state_d = S_ERR;
                  end else begin
                     if (pend_q) begin
                        we_d    = 1'b1;
                        waddr_d = base_q + ADDR_W'(cnt_q);
                        wdata_d = acc_q;
                        cnt_d   = cnt_after;
                     end
                     // A line break after at least one element pads the rest with zeros.
                     if (pend_q && (cnt_after == total_q)) begin
                        state_d = S_DONE;
                     end else if (is_eol && (cnt_after != '0)) begin
                        state_d = S_FILL;
                     end
                  end
               end
            end
         end
         S_FILL: begin
            we_d    = 1'b1;
            waddr_d = base_q + ADDR_W'(cnt_q);
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if ((cnt_q + 1'b1) == total_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE, S_ERR: begin
            if (!bus.w_en_input) begin
               err_d   = 2'd0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.w_storage_we    = we_q;
   assign bus.w_storage_waddr = waddr_q;
   assign bus.w_storage_wdata = 32'(wdata_q);
   assign bus.o_in_m          = 32'(m_q);
   assign bus.o_in_n          = 32'(n_q);
   assign bus.w_in_done       = (state_q == S_DONE) || (state_q == S_ERR);
   assign bus.w_in_err        = err_q;
endmodule
